// File: rtl/uart_send_scheduler.sv
// Round-robin scheduler that presents one non-zero channel byte at a time to a UART
// transmitter, either cyclically or only when a channel's value has changed since its last send.
module uart_send_scheduler #(
  parameter int NUM_CH    = 3,
  parameter int DATA_W    = 8,
  parameter int ON_CHANGE = 0
) (
  input  logic                      uart_clk,
  input  logic                      rst_n,
  input  logic [NUM_CH*DATA_W-1:0]  ch_data,
  input  logic                      tx_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_valid,
  output logic [$clog2(NUM_CH)-1:0] tx_ch,
  output logic [7:0]                sent_count
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic {SCAN, SEND} state_t;

  state_t            state;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   ptr_next;
  logic [DATA_W-1:0] last_sent [NUM_CH];
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] cur_last;
  logic              eligible;

  // Decoded selects keep ptr values beyond NUM_CH-1 (non-power-of-two counts) harmless.
  always_comb begin
    cur      = '0;
    cur_last = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ptr == CH_W'(k)) begin
        cur      = ch_data[k*DATA_W +: DATA_W];
        cur_last = last_sent[k];
      end
    end
    eligible = (cur != '0) && ((ON_CHANGE == 0) || (cur != cur_last));
    ptr_next = (ptr == CH_W'(NUM_CH - 1)) ? '0 : ptr + 1'b1;
  end

  always_ff @(posedge uart_clk) begin
    if (!rst_n) begin
      state      <= SCAN;
      ptr        <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      tx_ch      <= '0;
      sent_count <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) last_sent[k] <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (eligible) begin
            tx_data  <= cur;
            tx_ch    <= ptr;
            tx_valid <= 1'b1;
            state    <= SEND;
          end else begin
            ptr <= ptr_next;
          end
        end
        SEND: begin
          // ptr still equals tx_ch here, so ptr_next resumes scanning after the sent channel.
          if (tx_ready) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
              if (tx_ch == CH_W'(k)) last_sent[k] <= tx_data;
            end
            sent_count <= sent_count + 8'd1;
            ptr        <= ptr_next;
            tx_valid   <= 1'b0;
            state      <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_send_scheduler.sv
// Bench for uart_send_scheduler: three instances (cyclic/3ch, on-change/3ch, cyclic/5ch)
// checked every cycle against a per-channel reference model, plus directed scenarios.
module tb_uart_send_scheduler;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic        tx_ready;
  logic [39:0] bus;

  logic [7:0] d0, d1, d2, n0, n1, n2;
  logic       v0, v1, v2;
  logic [1:0] c0, c1;
  logic [2:0] c2;

  always #5 clk = ~clk;

  uart_send_scheduler #(.NUM_CH(3), .DATA_W(8), .ON_CHANGE(0)) u_cyc3 (
    .uart_clk(clk), .rst_n(rst_n[0]), .ch_data(bus[23:0]), .tx_ready(tx_ready),
    .tx_data(d0), .tx_valid(v0), .tx_ch(c0), .sent_count(n0));

  uart_send_scheduler #(.NUM_CH(3), .DATA_W(8), .ON_CHANGE(1)) u_chg3 (
    .uart_clk(clk), .rst_n(rst_n[1]), .ch_data(bus[23:0]), .tx_ready(tx_ready),
    .tx_data(d1), .tx_valid(v1), .tx_ch(c1), .sent_count(n1));

  uart_send_scheduler #(.NUM_CH(5), .DATA_W(8), .ON_CHANGE(0)) u_cyc5 (
    .uart_clk(clk), .rst_n(rst_n[2]), .ch_data(bus), .tx_ready(tx_ready),
    .tx_data(d2), .tx_valid(v2), .tx_ch(c2), .sent_count(n2));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int nch [3] = '{3, 3, 5};
  int onc [3] = '{0, 1, 0};

  // Reference model: one pending byte per instance, last byte sent per channel.
  bit m_send [3];
  int m_ptr  [3];
  int m_data [3];
  int m_ch   [3];
  int m_cnt  [3];
  int m_last [3][8];

  // Acceptance log: channel, byte and cycle of every handshake.
  int nacc     [3];
  int log_ch   [3][600];
  int log_data [3][600];
  int log_cyc  [3][600];

  task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s inst%0d cyc%0d: observed %0h expected %0h", tag, i, cyc, obs, exp);
    end
  endtask

  function automatic void get_obs(input int i, output logic v, output logic [7:0] d,
                                  output logic [2:0] c, output logic [7:0] n);
    case (i)
      0:       begin v = v0; d = d0; c = {1'b0, c0}; n = n0; end
      1:       begin v = v1; d = d1; c = {1'b0, c1}; n = n1; end
      default: begin v = v2; d = d2; c = c2;         n = n2; end
    endcase
  endfunction

  function automatic void model_step(input int i);
    int v;
    if (!rst_n[i]) begin
      m_send[i] = 0; m_ptr[i] = 0; m_data[i] = 0; m_ch[i] = 0; m_cnt[i] = 0;
      for (int j = 0; j < 8; j++) m_last[i][j] = 0;
    end else if (m_send[i]) begin
      if (tx_ready) begin
        m_last[i][m_ch[i]] = m_data[i];
        m_cnt[i]  = (m_cnt[i] + 1) % 256;
        m_ptr[i]  = (m_ch[i] + 1) % nch[i];
        m_send[i] = 0;
      end
    end else begin
      v = int'((bus >> (8 * m_ptr[i])) & 40'hFF);
      if (v != 0 && (onc[i] == 0 || v != m_last[i][m_ptr[i]])) begin
        m_send[i] = 1; m_data[i] = v; m_ch[i] = m_ptr[i];
      end else begin
        m_ptr[i] = (m_ptr[i] + 1) % nch[i];
      end
    end
  endfunction

  task automatic cycle();
    logic v; logic [7:0] d; logic [2:0] c; logic [7:0] n;
    for (int i = 0; i < 3; i++) begin
      get_obs(i, v, d, c, n);
      if (rst_n[i] && v && tx_ready) begin
        if (nacc[i] < 600) begin
          log_ch[i][nacc[i]] = int'(c); log_data[i][nacc[i]] = int'(d); log_cyc[i][nacc[i]] = cyc;
        end
        nacc[i]++;
      end
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      get_obs(i, v, d, c, n);
      check("valid", i, v, m_send[i]);
      check("data", i, d, m_data[i]);
      check("ch", i, c, m_ch[i]);
      check("count", i, n, m_cnt[i]);
      if (v === 1'b1) check("nonzero_byte", i, d != 8'h00, 1);
    end
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom % 4)
      0:       return 8'h00;
      1:       return 8'h01;
      2:       return 8'h02;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int exp_seq [4] = '{'h11, 'h22, 'h33, 'h11};
    int guard;
    logic [7:0] held;
    logic [7:0] cnt0;

    for (int i = 0; i < 3; i++) nacc[i] = 0;
    rst_n = 3'b000; tx_ready = 1'b0; bus = '0;
    repeat (2) cycle();
    check("rst_valid", 0, v0, 0);
    check("rst_count", 1, n1, 0);
    check("rst_data", 2, d2, 0);

    // Cyclic order with all channels non-zero.
    bus = 40'h00_0033_2211; tx_ready = 1'b1; rst_n = 3'b111;
    nacc[0] = 0;
    repeat (14) cycle();
    check("cyc_count", 0, nacc[0] >= 4, 1);
    for (int k = 0; k < 4; k++) check("cyc_order", 0, log_data[0][k], exp_seq[k]);
    for (int k = 1; k < 4; k++) check("cyc_spacing", 0, log_cyc[0][k] - log_cyc[0][k-1], 2);

    // Zero channel is skipped.
    bus = 40'h00_0033_0011; rst_n[0] = 1'b0;
    cycle();
    rst_n[0] = 1'b1; nacc[0] = 0;
    repeat (20) cycle();
    check("zero_skip_count", 0, nacc[0] >= 6, 1);
    for (int k = 0; k < nacc[0] && k < 600; k++) begin
      check("zero_skip_ch", 0, log_ch[0][k] == 1, 0);
      check("zero_skip_data", 0, log_data[0][k] == 0, 0);
    end

    // Change-only: three initial sends, then one for the changed channel.
    bus = 40'h00_0005_0505; rst_n[1] = 1'b0;
    cycle();
    rst_n[1] = 1'b1; nacc[1] = 0;
    repeat (20) cycle();
    check("chg_initial_sends", 1, nacc[1], 3);
    bus = 40'h00_0007_0505; nacc[1] = 0;
    repeat (20) cycle();
    check("chg_update_sends", 1, nacc[1], 1);
    check("chg_update_ch", 1, log_ch[1][0], 2);
    check("chg_update_data", 1, log_data[1][0], 'h07);

    // Back-pressure: byte held while ch_data toggles.
    tx_ready = 1'b0; bus = 40'h00_0033_2211;
    guard = 0;
    while (!v0 && guard < 10) begin cycle(); guard++; end
    check("bp_reach_send", 0, v0, 1);
    held = d0; cnt0 = n0;
    repeat (20) begin
      bus[23:0] = 24'($urandom);
      cycle();
      check("bp_valid_hold", 0, v0, 1);
      check("bp_data_hold", 0, d0, held);
    end
    tx_ready = 1'b1; nacc[0] = 0;
    cycle();
    tx_ready = 1'b0;
    repeat (4) cycle();
    check("bp_one_accept", 0, nacc[0], 1);
    check("bp_count_inc", 0, n0, 8'(cnt0 + 8'd1));

    // Reset during SEND aborts the byte; it is sent again afterwards.
    bus = 40'h00_0000_0009; rst_n[1] = 1'b0;
    cycle();
    rst_n[1] = 1'b1;
    guard = 0;
    while (!v1 && guard < 10) begin cycle(); guard++; end
    check("rs_reach_send", 1, v1, 1);
    check("rs_pending", 1, d1, 'h09);
    rst_n[1] = 1'b0;
    cycle();
    check("rs_valid_clear", 1, v1, 0);
    check("rs_count_clear", 1, n1, 0);
    rst_n[1] = 1'b1; tx_ready = 1'b1; nacc[1] = 0;
    repeat (6) cycle();
    check("rs_resent", 1, nacc[1] >= 1, 1);
    check("rs_resent_data", 1, log_data[1][0], 'h09);

    // Randomized traffic, ready and occasional resets against the model.
    repeat (2000) begin
      for (int b = 0; b < 5; b++) bus[b*8 +: 8] = pick_byte();
      tx_ready = ($urandom % 3) != 0;
      for (int i = 0; i < 3; i++) rst_n[i] = ($urandom % 100) != 0;
      cycle();
    end

    // 256 acceptances wrap sent_count; five channels served in order.
    rst_n = 3'b011; bus = 40'h05_0403_0201; tx_ready = 1'b1;
    cycle();
    rst_n = 3'b111; nacc[2] = 0;
    guard = 0;
    while (nacc[2] < 256 && guard < 2000) begin cycle(); guard++; end
    check("wrap_accepts", 2, nacc[2], 256);
    check("wrap_count", 2, n2, 0);
    for (int k = 0; k < 10; k++) check("wrap_order", 2, log_ch[2][k], k % 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_send_scheduler.md
UART_SEND_SCHEDULER -- requirements
Module: uart_send_scheduler

Interface
REQ-001 Parameter NUM_CH, default 3, number of input byte channels (range 2..8).
REQ-002 Parameter DATA_W, default 8, width of each channel and of tx_data.
REQ-003 Parameter ON_CHANGE, default 0: 0 = cyclic resend mode, 1 = send-only-on-change mode.
REQ-004 The block SHALL use one clock, uart_clk, and a synchronous active-low reset, rst_n.
REQ-005 uart_clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset, sampled on uart_clk rising edge.
REQ-007 ch_data  input  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]; channel 0 = game state, 1 = target machine, 2 = operate machine.
REQ-008 tx_ready  input  1  UART transmitter accepts tx_data in any cycle where tx_valid and tx_ready are both 1.
REQ-009 tx_data  output  DATA_W  byte presented to the UART.
REQ-010 tx_valid  output  1  tx_data is valid and held.
REQ-011 tx_ch  output  clog2(NUM_CH)  channel index of the byte in tx_data.
REQ-012 sent_count  output  8  count of accepted bytes, intended for the LEDs.

Function
REQ-013 The FSM SHALL have two states: SCAN and SEND.
REQ-014 Pointer ptr SHALL select one channel per cycle in SCAN.
REQ-015 Channel ptr is eligible when its value is non-zero and, if ON_CHANGE=1, its value differs from last_sent[ptr].
REQ-016 A zero-valued channel SHALL never be sent, since 0x00 blocks the UART link.
REQ-017 In SCAN with channel ptr eligible, the block SHALL latch the value into tx_data, set tx_ch=ptr, and enter SEND on the next edge.
REQ-018 In SCAN with channel ptr ineligible, ptr SHALL advance by 1 and the block SHALL stay in SCAN.
REQ-019 ptr SHALL wrap from NUM_CH-1 to 0.
REQ-020 In SEND, tx_valid SHALL be 1, and tx_data and tx_ch SHALL stay stable regardless of changes on ch_data.
REQ-021 In SEND with tx_ready=1, the block SHALL, on that edge, write last_sent[tx_ch]=tx_data, increment sent_count, advance ptr, and return to SCAN, with tx_valid=0 in the next cycle.
REQ-022 In SEND with tx_ready=0, the block SHALL hold all state indefinitely; there is no timeout.
REQ-023 tx_valid SHALL be 0 in SCAN, so at most one byte is accepted per SEND entry.
REQ-024 Latency from an eligible channel at ptr to tx_valid=1 SHALL be 1 cycle.
REQ-025 The minimum spacing between consecutive accepted bytes SHALL be 2 cycles.
REQ-026 Arbitration SHALL be round-robin; after a send from channel k, scanning resumes at channel k+1 (mod NUM_CH).
REQ-027 sent_count SHALL wrap from 255 to 0 without saturating.
REQ-028 If a channel changes to a new non-zero value and back before being scanned, in ON_CHANGE=1 mode, no byte SHALL be sent for it.
REQ-029 tx_ready asserted while tx_valid=0 SHALL be ignored.

Reset
REQ-030 While rst_n=0 at a clock edge, the block SHALL enter SCAN and set ptr=0, tx_valid=0, tx_data=0, tx_ch=0, sent_count=0, and every last_sent entry to 0.
REQ-031 A reset asserted during SEND SHALL abort the pending byte: tx_valid=0 next cycle, nothing recorded in last_sent, sent_count=0.

Verification
REQ-032 Cyclic order: ON_CHANGE=0, ch = {0x33,0x22,0x11}, tx_ready=1 always -> tx_data sequence 0x11,0x22,0x33,0x11,..., each byte 2 cycles apart.
REQ-033 Zero skip: ON_CHANGE=0, ch1=0x00, others non-zero -> channel 1 never appears on tx_ch, and 0x00 never appears with tx_valid=1.
REQ-034 Change-only: ON_CHANGE=1, all channels 0x05 -> exactly 3 sends, then idle. Then change ch2 to 0x07 -> exactly one send, tx_ch=2, tx_data=0x07.
REQ-035 Back-pressure: tx_ready=0 for 20 cycles in SEND while ch_data toggles -> tx_valid=1 and tx_data unchanged throughout. tx_ready=1 -> exactly one acceptance and sent_count +1.
REQ-036 Reset mid-send: rst_n=0 during SEND -> next cycle tx_valid=0 and sent_count=0. With ON_CHANGE=1, the aborted channel value is resent after reset.
REQ-037 Wrap: force 256 acceptances -> sent_count returns to 0. With NUM_CH=5, ptr wraps 4->0 and all 5 channels are served in order.
